pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/flush controller; the producer of the flush and load-enable signals consumed by the IF/ID and ID/EXE pipeline registers.
Keeps a two-slot scoreboard of in-flight destinations (EXE, MEM) and detects RAW hazards on the instruction in ID.
Applies branch-taken flushes from EXE.
Freezes the whole pipeline while a multi-cycle SRAM access in MEM is outstanding.

Parameters:
FORWARDING_EN, 1, 1 = forwarding unit present, so stall only on load-use; 0 = stall on any EXE/MEM RAW match.
MEM_TIMEOUT, 31, maximum wait cycles for mem_ready before mem_error is raised.
TMO_W, 5, width of the wait counter; must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
id_src1  in  `LEN_REG_ADDRESS  Rn of the instruction in ID
id_src2  in  `LEN_REG_ADDRESS  Rm/Rd source of the instruction in ID
id_two_src  in  1  id_src2 is a real operand (not immediate, or a store)
id_dest  in  `LEN_REG_ADDRESS  destination of the instruction in ID
id_wb_en  in  1  ID instruction writes the register file
id_mem_read  in  1  ID instruction is a load
branch_taken  in  1  EXE resolved a taken branch this cycle
mem_req  in  1  MEM stage holds a load or store
mem_ready  in  1  SRAM controller completion strobe
pc_ld  out  1  PC register load enable
if_id_ld  out  1  IF/ID register load enable
if_id_flush  out  1  IF/ID flush
id_exe_ld  out  1  ID/EXE load enable
id_exe_flush  out  1  ID/EXE flush; inserts a bubble
exe_mem_ld  out  1  EXE/MEM load enable
mem_wb_ld  out  1  MEM/WB load enable
hazard  out  1  RAW stall asserted this cycle (debug)
mem_error  out  1  sticky; set on timeout, cleared only by rst

Behaviour:
- All outputs are combinational from state and inputs, except mem_error, which is registered.
- Scoreboard slots: exe_slot and mem_slot, each {valid, dest, wb_en, mem_read}.
- On rst:
  - both slots invalid; FSM in RUN; wait counter 0; mem_error 0.
  - outputs during rst: all *_ld 1, flushes 0, hazard 0.
- Hazard detect (combinational):
  - match_x = exe_slot.valid & exe_slot.wb_en & (dest == id_src1, or dest == id_src2 & id_two_src); match_m is the same check on mem_slot.
  - FORWARDING_EN=1: hazard = match_x & exe_slot.mem_read.
  - FORWARDING_EN=0: hazard = match_x | match_m.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when mem_req & !mem_ready.
  - MEM_WAIT -> RUN when mem_ready.
  - mem_req & mem_ready in the same cycle stays in RUN; this is a single-cycle access with no freeze.
- Freeze (state MEM_WAIT, or RUN with mem_req & !mem_ready):
  - all *_ld 0, both flushes 0, hazard output 0.
  - scoreboard holds; wait counter increments.
- Timeout: when the counter reaches MEM_TIMEOUT, mem_error sets. The counter saturates and the freeze continues until mem_ready.
- Counter clears whenever the FSM is in RUN.
- Priority (highest first): freeze > branch_taken > hazard.
- branch_taken, not frozen:
  - if_id_flush=1 and id_exe_flush=1; all ld 1.
  - hazard is suppressed because the ID instruction is squashed.
- hazard, not frozen, no branch:
  - pc_ld=0, if_id_ld=0; id_exe_flush=1 (bubble); exe/mem/wb ld 1.
- Otherwise: all ld 1, flushes 0.
- Scoreboard update, every non-frozen cycle:
  - mem_slot <= exe_slot.
  - exe_slot <= id_exe_flush ? invalid : {1, id_dest, id_wb_en, id_mem_read}.
- The stall latency for a load-use pair is exactly 1 bubble with forwarding, and up to 2 without.
- Dest 0 is not special; every register compares normally.
- rst asserted during MEM_WAIT returns to RUN immediately, with no pending freeze.

Decomposition:
- Add to ISA.v: `LEN_REG_ADDRESS (already present), FSM state encodings `PC_RUN and `PC_MEM_WAIT, and a default `MEM_TIMEOUT.
- One natural sub-module: hazard_compare, the combinational slot-vs-source matcher, instantiated for exe_slot and mem_slot.

Test Plan:
- Load-use hazard, FORWARDING_EN=1:
  - Stimulus: LDR R3 (id_dest=3, id_mem_read=1), then ADD with id_src1=3.
  - Required: hazard=1 for exactly 1 cycle; pc_ld=0, if_id_ld=0, id_exe_flush=1; then normal flow.
- No-forwarding RAW, FORWARDING_EN=0:
  - Stimulus: ADD R5 writer followed immediately by a reader of R5.
  - Required: 2 consecutive stall cycles (EXE match, then MEM match), then release.
- Branch overriding a hazard:
  - Stimulus: hazard condition true and branch_taken=1 in the same cycle.
  - Required: if_id_flush=1, id_exe_flush=1, pc_ld=1, hazard=0; exe_slot becomes invalid.
- Memory wait:
  - Stimulus: mem_req=1, mem_ready low for 4 cycles, then high.
  - Required: all ld 0 for 4 cycles; scoreboard unchanged; ld back to 1 in the cycle mem_ready=1; FSM returns to RUN.
- Timeout:
  - Stimulus: mem_req=1 and mem_ready=0 for 40 cycles with MEM_TIMEOUT=31.
  - Required: mem_error rises after 31 wait cycles and stays high after mem_ready; it clears only on rst.
- Reset mid-wait:
  - Stimulus: assert rst during MEM_WAIT.
  - Required: next cycle all ld 1, mem_error 0, slots invalid, no hazard on any source.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
// Register address width, FSM encodings and scoreboard slot layout.
package pipeline_ctrl_pkg;

    localparam int LEN_REG_ADDRESS = 4;
    localparam int MEM_TIMEOUT_DEF = 31;

    typedef logic [LEN_REG_ADDRESS-1:0] reg_addr_t;

    typedef enum logic {
        PC_RUN      = 1'b0,
        PC_MEM_WAIT = 1'b1
    } pc_state_e;

    typedef struct packed {
        logic      valid;
        reg_addr_t dest;
        logic      wb_en;
        logic      mem_read;
    } slot_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_compare.sv
// Matches one in-flight scoreboard slot against the ID-stage sources.
// LOAD_ONLY restricts the match to slots holding a load.
module pipeline_ctrl_hazard_compare
    import pipeline_ctrl_pkg::*;
#(
    parameter bit LOAD_ONLY = 1'b0
) (
    input  slot_t     slot_i,
    input  reg_addr_t src1_i,
    input  reg_addr_t src2_i,
    input  logic      two_src_i,
    output logic      match_o
);

    logic hit;

    assign hit = slot_i.valid & slot_i.wb_en &
                 ((slot_i.dest == src1_i) |
                  ((slot_i.dest == src2_i) & two_src_i));

    assign match_o = hit & (!LOAD_ONLY || slot_i.mem_read);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: RAW scoreboard, branch flush,
// and whole-pipeline freeze while an SRAM access is outstanding.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter bit FORWARDING_EN = 1'b1,
    parameter int MEM_TIMEOUT   = MEM_TIMEOUT_DEF,
    parameter int TMO_W         = 5
) (
    input  logic      clk,
    input  logic      rst,
    input  reg_addr_t id_src1,
    input  reg_addr_t id_src2,
    input  logic      id_two_src,
    input  reg_addr_t id_dest,
    input  logic      id_wb_en,
    input  logic      id_mem_read,
    input  logic      branch_taken,
    input  logic      mem_req,
    input  logic      mem_ready,
    output logic      pc_ld,
    output logic      if_id_ld,
    output logic      if_id_flush,
    output logic      id_exe_ld,
    output logic      id_exe_flush,
    output logic      exe_mem_ld,
    output logic      mem_wb_ld,
    output logic      hazard,
    output logic      mem_error
);

    localparam logic [TMO_W-1:0] TMO = TMO_W'(MEM_TIMEOUT);

    pc_state_e        state_q, state_d;
    slot_t            exe_q, exe_d;
    slot_t            mem_q, mem_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             frozen, raw;
    logic             match_x, match_m;

    pipeline_ctrl_hazard_compare #(
        .LOAD_ONLY (FORWARDING_EN)
    ) u_cmp_exe (
        .slot_i    (exe_q),
        .src1_i    (id_src1),
        .src2_i    (id_src2),
        .two_src_i (id_two_src),
        .match_o   (match_x)
    );

    pipeline_ctrl_hazard_compare #(
        .LOAD_ONLY (1'b0)
    ) u_cmp_mem (
        .slot_i    (mem_q),
        .src1_i    (id_src1),
        .src2_i    (id_src2),
        .two_src_i (id_two_src),
        .match_o   (match_m)
    );

    // With forwarding only a load in EXE can stall; MEM is forwarded.
    assign raw = FORWARDING_EN ? match_x : (match_x | match_m);

    assign frozen = !mem_ready &&
                    ((state_q == PC_MEM_WAIT) || mem_req);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PC_RUN:      if (mem_req && !mem_ready) state_d = PC_MEM_WAIT;
            PC_MEM_WAIT: if (mem_ready) state_d = PC_RUN;
            default:     state_d = PC_RUN;
        endcase
    end

    always_comb begin
        pc_ld        = 1'b1;
        if_id_ld     = 1'b1;
        if_id_flush  = 1'b0;
        id_exe_ld    = 1'b1;
        id_exe_flush = 1'b0;
        exe_mem_ld   = 1'b1;
        mem_wb_ld    = 1'b1;
        hazard       = 1'b0;
        if (rst) begin
            hazard = 1'b0;
        end else if (frozen) begin
            pc_ld      = 1'b0;
            if_id_ld   = 1'b0;
            id_exe_ld  = 1'b0;
            exe_mem_ld = 1'b0;
            mem_wb_ld  = 1'b0;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end else if (raw) begin
            pc_ld        = 1'b0;
            if_id_ld     = 1'b0;
            id_exe_flush = 1'b1;
            hazard       = 1'b1;
        end
    end

    always_comb begin
        exe_d = exe_q;
        mem_d = mem_q;
        if (!frozen) begin
            mem_d = exe_q;
            if (id_exe_flush) begin
                exe_d = '0;
            end else begin
                exe_d = '{valid:    1'b1,
                          dest:     id_dest,
                          wb_en:    id_wb_en,
                          mem_read: id_mem_read};
            end
        end
    end

    // The counter only runs while frozen, so it is zero throughout RUN.
    always_comb begin
        cnt_d = '0;
        if (frozen) begin
            cnt_d = (cnt_q == TMO) ? cnt_q : cnt_q + TMO_W'(1);
        end
        err_d = err_q | (cnt_d == TMO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PC_RUN;
            exe_q   <= '0;
            mem_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exe_q   <= exe_d;
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign mem_error = err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl, with and without forwarding.
// Expected output vectors are queued per step and popped at sampling.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_src1, id_src2, id_dest;
    logic       id_two_src, id_wb_en, id_mem_read;
    logic       branch_taken, mem_req, mem_ready;

    logic f_pc, f_ifld, f_iffl, f_idld, f_idfl;
    logic f_exld, f_wbld, f_haz, f_err;
    logic n_pc, n_ifld, n_iffl, n_idld, n_idfl;
    logic n_exld, n_wbld, n_haz, n_err;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .FORWARDING_EN (1'b1),
        .MEM_TIMEOUT   (31),
        .TMO_W         (5)
    ) u_fw (
        .clk          (clk),
        .rst          (rst),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .id_dest      (id_dest),
        .id_wb_en     (id_wb_en),
        .id_mem_read  (id_mem_read),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_ld        (f_pc),
        .if_id_ld     (f_ifld),
        .if_id_flush  (f_iffl),
        .id_exe_ld    (f_idld),
        .id_exe_flush (f_idfl),
        .exe_mem_ld   (f_exld),
        .mem_wb_ld    (f_wbld),
        .hazard       (f_haz),
        .mem_error    (f_err)
    );

    pipeline_ctrl #(
        .FORWARDING_EN (1'b0),
        .MEM_TIMEOUT   (31),
        .TMO_W         (5)
    ) u_nf (
        .clk          (clk),
        .rst          (rst),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .id_dest      (id_dest),
        .id_wb_en     (id_wb_en),
        .id_mem_read  (id_mem_read),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_ld        (n_pc),
        .if_id_ld     (n_ifld),
        .if_id_flush  (n_iffl),
        .id_exe_ld    (n_idld),
        .id_exe_flush (n_idfl),
        .exe_mem_ld   (n_exld),
        .mem_wb_ld    (n_wbld),
        .hazard       (n_haz),
        .mem_error    (n_err)
    );

    // {pc,if_id_ld,if_id_fl,id_exe_ld,id_exe_fl,exe_ld,wb_ld,haz,err}
    localparam logic [8:0] VN = 9'b110101100;
    localparam logic [8:0] VH = 9'b000111110;
    localparam logic [8:0] VB = 9'b111111100;
    localparam logic [8:0] VF = 9'b000000000;
    localparam logic [8:0] VE = 9'b000000001;
    localparam bit FW = 1'b1;
    localparam bit NF = 1'b0;

    typedef struct {
        string      tag;
        bit         sel;
        logic [8:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [8:0] obs(bit sel);
        if (sel)
            return {f_pc, f_ifld, f_iffl, f_idld, f_idfl,
                    f_exld, f_wbld, f_haz, f_err};
        return {n_pc, n_ifld, n_iffl, n_idld, n_idfl,
                n_exld, n_wbld, n_haz, n_err};
    endfunction

    task automatic push(string tag, bit sel, logic [8:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.v   = v;
        q.push_back(e);
    endtask

    task automatic sample();
        exp_t       e;
        logic [8:0] o;
        #2;
        while (q.size() > 0) begin
            e = q.pop_front();
            o = obs(e.sel);
            checks++;
            assert (o === e.v) else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b",
                       e.tag, o, e.v);
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] s1, input logic [3:0] s2,
                         input logic two, input logic [3:0] d,
                         input logic wb, input logic mr,
                         input logic br, input logic rq,
                         input logic rdy);
        id_src1      = s1;
        id_src2      = s2;
        id_two_src   = two;
        id_dest      = d;
        id_wb_en     = wb;
        id_mem_read  = mr;
        branch_taken = br;
        mem_req      = rq;
        mem_ready    = rdy;
    endtask

    task automatic nop(input logic rq, input logic rdy);
        drive(4'd15, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, rq, rdy);
    endtask

    task automatic do_rst(input bit chk, input string tag);
        rst = 1'b1;
        nop(1'b0, 1'b0);
        if (chk) begin
            push({tag, "_fw"}, FW, VN);
            push({tag, "_nf"}, NF, VN);
        end
        sample();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        nop(1'b0, 1'b0);
        @(negedge clk);
        do_rst(1'b1, "reset");

        // load-use with forwarding: one bubble
        drive(4'd15, 4'd15, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push("lu_ldr", FW, VN);
        sample();
        drive(4'd3, 4'd15, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("lu_stall", FW, VH);
        sample();
        push("lu_release", FW, VN);
        sample();
        nop(1'b0, 1'b0);
        push("lu_after", FW, VN);
        sample();

        // no forwarding: EXE match then MEM match via src2
        do_rst(1'b1, "rst2");
        drive(4'd15, 4'd15, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("nf_wr", NF, VN);
        sample();
        drive(4'd15, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("nf_stall_x", NF, VH);
        push("fw_no_stall_alu", FW, VN);
        sample();
        push("nf_stall_m", NF, VH);
        sample();
        push("nf_release", NF, VN);
        sample();

        // src2 is an immediate: no hazard
        do_rst(1'b1, "rst3");
        drive(4'd15, 4'd15, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("imm_wr", NF, VN);
        sample();
        drive(4'd15, 4'd7, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("imm_no_haz", NF, VN);
        sample();

        // register 0 compares like any other
        do_rst(1'b1, "rst4");
        drive(4'd15, 4'd15, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("r0_wr", NF, VN);
        sample();
        drive(4'd0, 4'd15, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("r0_haz_nf", NF, VH);
        push("r0_none_fw", FW, VN);
        sample();

        // branch overrides a pending hazard
        do_rst(1'b1, "rst5");
        drive(4'd15, 4'd15, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push("br_ldr", FW, VN);
        sample();
        drive(4'd3, 4'd15, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        push("br_fw", FW, VB);
        push("br_nf", NF, VB);
        sample();
        drive(4'd3, 4'd15, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("br_exe_inv_fw", FW, VN);
        push("br_mem_shift_nf", NF, VH);
        sample();

        // multi-cycle memory access freezes everything
        do_rst(1'b1, "rst6");
        drive(4'd15, 4'd15, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push("mw_ldr", FW, VN);
        sample();
        for (int k = 1; k <= 4; k++) begin
            drive(4'd3, 4'd15, 1'b0, 4'd4, 1'b1, 1'b0,
                  1'b0, 1'b1, 1'b0);
            push($sformatf("mw_freeze%0d", k), FW, VF);
            sample();
        end
        drive(4'd3, 4'd15, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        push("mw_ready_sb_held", FW, VH);
        sample();
        drive(4'd3, 4'd15, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("mw_run", FW, VN);
        sample();
        nop(1'b1, 1'b1);
        push("mw_single_cycle", FW, VN);
        sample();
        nop(1'b0, 1'b0);
        push("mw_still_run", FW, VN);
        sample();

        // timeout after 31 frozen cycles, sticky until reset
        do_rst(1'b1, "rst7");
        for (int k = 1; k <= 40; k++) begin
            nop(1'b1, 1'b0);
            push($sformatf("tmo_c%0d", k), FW,
                 (k >= 32) ? VE : VF);
            sample();
        end
        nop(1'b0, 1'b1);
        push("tmo_ready", FW, VN | VE);
        sample();
        nop(1'b0, 1'b0);
        push("tmo_sticky", FW, VN | VE);
        sample();
        do_rst(1'b0, "rst8");
        nop(1'b0, 1'b0);
        push("tmo_cleared", FW, VN);
        sample();

        // reset in the middle of a wait
        drive(4'd15, 4'd15, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("rw_wr", NF, VN);
        sample();
        for (int k = 1; k <= 3; k++) begin
            nop(1'b1, 1'b0);
            push($sformatf("rw_freeze%0d", k), NF, VF);
            sample();
        end
        rst = 1'b1;
        nop(1'b1, 1'b0);
        push("rw_in_rst_fw", FW, VN);
        push("rw_in_rst_nf", NF, VN);
        sample();
        rst = 1'b0;
        drive(4'd9, 4'd9, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("rw_after_nf", NF, VN);
        push("rw_after_fw", FW, VN);
        sample();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
